// File: rtl/rou_arb4_if.sv
// Bundles the four requester streams and the arbitrated output of rou_arb4.
// The slave modport is the arbiter side; master is the requester/downstream side.
interface rou_arb4_if #(
  parameter int DWID = 128,
  parameter int AWID = 32,
  parameter int TWID = 5
);
  localparam int BWID = (DWID == 512) ? 6 : (DWID == 256) ? 5 :
                        (DWID == 128) ? 4 : (DWID == 64)  ? 3 : 2;
  localparam int WID  = 2 + DWID + AWID + BWID + TWID;

  logic [WID-1:0] rou0_in, rou1_in, rou2_in, rou3_in;
  logic           rou0_in_seen, rou1_in_seen, rou2_in_seen, rou3_in_seen;
  logic [2:0]     ack0_in, ack1_in, ack2_in, ack3_in;
  logic [WID-1:0] rou_out;
  logic           rou_out_seen;
  logic [1:0]     rou_out_src;
  logic [2:0]     ack_out;

  modport slave (
    input  rou0_in, rou1_in, rou2_in, rou3_in,
    input  rou0_in_seen, rou1_in_seen, rou2_in_seen, rou3_in_seen,
    output ack0_in, ack1_in, ack2_in, ack3_in,
    output rou_out, rou_out_seen, rou_out_src,
    input  ack_out
  );

  modport master (
    output rou0_in, rou1_in, rou2_in, rou3_in,
    output rou0_in_seen, rou1_in_seen, rou2_in_seen, rou3_in_seen,
    input  ack0_in, ack1_in, ack2_in, ack3_in,
    input  rou_out, rou_out_seen, rou_out_src,
    output ack_out
  );
endinterface

// File: rtl/rou_arb4.sv
// Four-to-one round-robin roubus arbiter with burst lock and a one-entry
// output register that can be consumed and reloaded in the same cycle.
module rou_arb4_lane (
  input  logic [1:0] code,
  input  logic       sel,
  output logic       vld,
  output logic [2:0] ack
);
  assign vld = (code != 2'b00);
  assign ack = sel ? 3'b001 : 3'b000;
endmodule

module rou_arb4 #(
  parameter int DWID = 128,
  parameter int AWID = 32,
  parameter int TWID = 5
) (
  input logic        clk,
  input logic        rst_n,
  rou_arb4_if.slave  bus
);
  localparam int BWID = (DWID == 512) ? 6 : (DWID == 256) ? 5 :
                        (DWID == 128) ? 4 : (DWID == 64)  ? 3 : 2;
  localparam int WID  = 2 + DWID + AWID + BWID + TWID;
  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE, LOCK} state_t;

  logic [NUM_LANES-1:0][WID-1:0] req_msg;
  logic [NUM_LANES-1:0][2:0]     lane_ack;
  logic [NUM_LANES-1:0]          req_seen, req_vld, lane_sel;

  state_t         state_q, state_d;
  logic [1:0]     rr_q, rr_d, lock_q, lock_d;
  logic           out_valid;
  logic [WID-1:0] out_msg;
  logic           out_seen;
  logic [1:0]     out_src;

  logic           slot_free, found, grant;
  logic [1:0]     win, win_code;

  assign req_msg  = {bus.rou3_in, bus.rou2_in, bus.rou1_in, bus.rou0_in};
  assign req_seen = {bus.rou3_in_seen, bus.rou2_in_seen, bus.rou1_in_seen, bus.rou0_in_seen};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rou_arb4_lane u_lane (
      .code (req_msg[g][1:0]),
      .sel  (lane_sel[g]),
      .vld  (req_vld[g]),
      .ack  (lane_ack[g])
    );
  end

  assign bus.ack0_in = lane_ack[0];
  assign bus.ack1_in = lane_ack[1];
  assign bus.ack2_in = lane_ack[2];
  assign bus.ack3_in = lane_ack[3];

  // Consume and reload can happen in the same cycle, so the slot is also free
  // while the downstream is taking the current entry.
  assign slot_free = !out_valid || (bus.ack_out != 3'b000);

  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    if (state_q == LOCK) begin
      found = req_vld[lock_q];
      win   = lock_q;
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        idx = rr_q + k[1:0];
        if (!found && req_vld[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end
  end

  // Acks are held low while reset is asserted even though state is idle.
  assign grant    = found && slot_free && rst_n;
  assign win_code = req_msg[win][1:0];
  assign lane_sel = grant ? (NUM_LANES'(1) << win) : '0;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    if (grant) begin
      case (state_q)
        IDLE: begin
          rr_d = win + 2'd1;
          if (win_code == 2'b10) begin
            state_d = LOCK;
            lock_d  = win;
          end
        end
        LOCK: begin
          if (win_code != 2'b10) begin
            state_d = IDLE;
            rr_d    = lock_q + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 2'd0;
      lock_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
    end
  end

  // Register contents are zeroed when drained so the outputs read 0 when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_msg   <= '0;
      out_seen  <= 1'b0;
      out_src   <= 2'd0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_msg   <= req_msg[win];
      out_seen  <= req_seen[win];
      out_src   <= win;
    end else if (slot_free) begin
      out_valid <= 1'b0;
      out_msg   <= '0;
      out_seen  <= 1'b0;
      out_src   <= 2'd0;
    end
  end

  assign bus.rou_out      = out_msg;
  assign bus.rou_out_seen = out_seen;
  assign bus.rou_out_src  = out_src;
endmodule

// File: tb/tb_rou_arb4.sv
// Directed vector bench for rou_arb4: hand-computed grant table plus reset sequences.
module tb_rou_arb4;
  localparam int DWID = 128, AWID = 32, TWID = 5, BWID = 4;
  localparam int WID  = 2 + DWID + AWID + BWID + TWID;
  localparam int NV   = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rou_arb4_if #(.DWID(DWID), .AWID(AWID), .TWID(TWID)) ifc ();
  rou_arb4 #(.DWID(DWID), .AWID(AWID), .TWID(TWID)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  typedef struct {
    logic [3:0][1:0] code;
    logic [3:0]      seen;
    logic [2:0]      ack_out;
    logic [3:0]      exp_ack;
  } vec_t;

  vec_t vt[NV];
  int n_run = 0, n_fail = 0;

  // expected output register contents
  logic           mv = 1'b0, mseen = 1'b0;
  logic [WID-1:0] mmsg = '0;
  logic [1:0]     msrc = 2'd0;
  logic [WID-1:0] cur_msg[4];
  logic [3:0]     cur_seen;
  logic [2:0]     cur_ao;

  function automatic logic [7:0] C(logic [1:0] c0, logic [1:0] c1, logic [1:0] c2, logic [1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [WID-1:0] msg_of(int idx, int n, logic [1:0] c);
    logic [WID-1:0] m;
    logic [7:0] ib, nb;
    ib = idx[7:0];
    nb = n[7:0];
    m = '0;
    m[1:0] = c;
    m[17:2] = {nb, ib};
    m[WID-1 -: 8] = 8'hA5 ^ ib;
    return m;
  endfunction

  task automatic chk(string name, logic [WID-1:0] act, logic [WID-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(int idx, logic [3:0][1:0] code, logic [3:0] seen, logic [2:0] ao);
    for (int n = 0; n < 4; n++) cur_msg[n] = msg_of(idx, n, code[n]);
    cur_seen = seen;
    cur_ao   = ao;
    ifc.rou0_in = cur_msg[0];
    ifc.rou1_in = cur_msg[1];
    ifc.rou2_in = cur_msg[2];
    ifc.rou3_in = cur_msg[3];
    {ifc.rou3_in_seen, ifc.rou2_in_seen, ifc.rou1_in_seen, ifc.rou0_in_seen} = seen;
    ifc.ack_out = ao;
  endtask

  // Checks acks and the output register, then advances the expected register.
  task automatic check_cycle(string tag, logic [3:0] exp_ack);
    logic [11:0] ea;
    #1;
    for (int n = 0; n < 4; n++) ea[n*3 +: 3] = exp_ack[n] ? 3'b001 : 3'b000;
    chk({tag, "_ack"}, WID'({ifc.ack3_in, ifc.ack2_in, ifc.ack1_in, ifc.ack0_in}), WID'(ea));
    chk({tag, "_out"}, ifc.rou_out, mmsg);
    chk({tag, "_seen"}, WID'(ifc.rou_out_seen), WID'(mseen));
    chk({tag, "_src"}, WID'(ifc.rou_out_src), WID'(msrc));
    if (!mv || cur_ao != 3'b000) begin
      mv = 1'b0; mmsg = '0; mseen = 1'b0; msrc = 2'd0;
      for (int n = 0; n < 4; n++)
        if (exp_ack[n]) begin
          mv = 1'b1; mmsg = cur_msg[n]; mseen = cur_seen[n]; msrc = 2'(n);
        end
    end
  endtask

  task automatic model_reset();
    mv = 1'b0; mmsg = '0; mseen = 1'b0; msrc = 2'd0;
  endtask

  initial begin
    // round robin over all four
    vt[0]  = '{C(1,1,1,1), 4'hA, 3'd1, 4'b0001};
    vt[1]  = '{C(1,1,1,1), 4'h5, 3'd1, 4'b0010};
    vt[2]  = '{C(1,1,1,1), 4'hA, 3'd1, 4'b0100};
    vt[3]  = '{C(1,1,1,1), 4'h5, 3'd1, 4'b1000};
    vt[4]  = '{C(1,1,1,1), 4'hF, 3'd1, 4'b0001};
    // fairness between 1 and 3
    vt[5]  = '{C(0,1,0,1), 4'hA, 3'd1, 4'b0010};
    vt[6]  = '{C(0,1,0,1), 4'hA, 3'd1, 4'b1000};
    vt[7]  = '{C(0,1,0,1), 4'h2, 3'd1, 4'b0010};
    vt[8]  = '{C(0,1,0,1), 4'h8, 3'd1, 4'b1000};
    // five stalled cycles, then release
    vt[9]  = '{C(0,1,0,1), 4'hF, 3'd0, 4'b0000};
    vt[10] = '{C(0,1,0,1), 4'hF, 3'd0, 4'b0000};
    vt[11] = '{C(0,1,0,1), 4'hF, 3'd0, 4'b0000};
    vt[12] = '{C(0,1,0,1), 4'hF, 3'd0, 4'b0000};
    vt[13] = '{C(0,1,0,1), 4'hF, 3'd0, 4'b0000};
    vt[14] = '{C(0,1,0,1), 4'h0, 3'd1, 4'b0010};
    // burst from 2 while 0 and 3 wait
    vt[15] = '{C(1,0,2,1), 4'h4, 3'd1, 4'b0100};
    vt[16] = '{C(1,0,2,1), 4'h0, 3'd1, 4'b0100};
    vt[17] = '{C(1,0,3,1), 4'h4, 3'd1, 4'b0100};
    vt[18] = '{C(1,0,0,1), 4'h9, 3'd1, 4'b1000};
    // lock held by idle requester 1
    vt[19] = '{C(0,2,0,0), 4'h2, 3'd1, 4'b0010};
    vt[20] = '{C(1,0,0,0), 4'h1, 3'd1, 4'b0000};
    vt[21] = '{C(1,0,0,0), 4'h1, 3'd1, 4'b0000};
    vt[22] = '{C(1,0,0,0), 4'h1, 3'd1, 4'b0000};
    vt[23] = '{C(1,0,0,0), 4'h1, 3'd1, 4'b0000};
    vt[24] = '{C(1,3,0,0), 4'h0, 3'd1, 4'b0010};
    // stray 11 from 0 is a single beat
    vt[25] = '{C(3,0,0,0), 4'h1, 3'd1, 4'b0001};
    vt[26] = '{C(1,0,1,0), 4'h4, 3'd1, 4'b0100};
    vt[27] = '{C(1,0,0,0), 4'h1, 3'd4, 4'b0001};
    vt[28] = '{C(0,0,0,0), 4'hF, 3'd1, 4'b0000};
    vt[29] = '{C(0,0,0,0), 4'hF, 3'd1, 4'b0000};

    drive(100, C(1,1,1,1), 4'hF, 3'd1);
    repeat (2) @(negedge clk);
    check_cycle("rst0", 4'b0000);
    @(negedge clk);
    check_cycle("rst1", 4'b0000);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      drive(i, vt[i].code, vt[i].seen, vt[i].ack_out);
      check_cycle($sformatf("v%0d", i), vt[i].exp_ack);
    end

    // reset in the middle of a burst from requester 3
    @(negedge clk);
    drive(40, C(0,0,0,2), 4'h8, 3'd1);
    check_cycle("mb0", 4'b1000);
    @(negedge clk);
    drive(41, C(1,0,0,2), 4'h8, 3'd1);
    check_cycle("mb1", 4'b1000);
    @(negedge clk);
    drive(42, C(1,0,0,2), 4'h8, 3'd1);
    rst_n = 1'b0;
    model_reset();
    check_cycle("mb_rst", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(43, C(1,0,0,2), 4'h1, 3'd1);
    check_cycle("mb_rel", 4'b0001);
    @(negedge clk);
    drive(44, C(0,0,0,0), 4'h0, 3'd1);
    check_cycle("mb_out", 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
